// File: rtl/jtcontra_snd_cmd_pkg.sv
// Shared definitions for the main-CPU sound command link: FSM state codes,
// command byte width and timer widths.
package jtcontra_snd_cmd_pkg;

    localparam int DATA_W   = 8;
    localparam int PULSE_TW = 4;
    localparam int GAP_TW   = 8;
    localparam int TO_TW    = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PULSE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

endpackage

// File: rtl/jtcontra_snd_cmd_fifo.sv
// Synchronous DEPTH x 8 command FIFO; head is the oldest entry, count is
// log2(DEPTH)+1 bits, pointers wrap modulo DEPTH.
module jtcontra_snd_cmd_fifo
    import jtcontra_snd_cmd_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is still taken when a pop frees a slot this cycle
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/jtcontra_snd_cmd.sv
// Main-CPU side of the sound command link: latches command bytes and paces them
// to the sound CPU with snd_irq pulses. Define JTCONTRA_SNDCMD_FIFO_EN for a FIFO.
module jtcontra_snd_cmd
    import jtcontra_snd_cmd_pkg::*;
#(
    parameter int IRQ_W   = 4,
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 4096,
    parameter int DEPTH   = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              main_cs,
    input  logic              main_we,
    input  logic [DATA_W-1:0] main_din,
    input  logic              snd_ack,
    output logic [DATA_W-1:0] snd_latch,
    output logic              snd_irq,
    output logic              busy,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PULSE_TW-1:0] IRQ_LAST = PULSE_TW'(IRQ_W - 1);
    localparam logic [GAP_TW-1:0]   GAP_LAST = GAP_TW'(GAP_W - 1);
    localparam logic [TO_TW-1:0]    TO_LAST  = TO_TW'(TIMEOUT - 1);
    localparam bit                  TO_EN    = (TIMEOUT != 0);

    state_t              state;
    logic [PULSE_TW-1:0] pulse_cnt;
    logic [GAP_TW-1:0]   gap_cnt;
    logic [TO_TW-1:0]    to_cnt;

    logic              wr;
    logic              pop;
    logic              to_hit;
    logic              has_cmd;
    logic              more;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head;

    assign wr       = cen & main_cs & main_we;
    assign to_hit   = TO_EN & cen & (to_cnt == TO_LAST);
    assign pop      = (state == ST_WAIT) & (snd_ack | to_hit);
    assign has_cmd  = (count != '0);
    assign snd_irq  = (state == ST_PULSE);
    assign busy     = (state != ST_IDLE);

`ifdef JTCONTRA_SNDCMD_FIFO_EN
    localparam bit RESTART = 1'b0;

    logic push;
    logic full;
    logic empty;

    assign push = wr & (~full | pop);
    assign more = (count > CNT_W'(1)) | push;

    jtcontra_snd_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (main_din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst)                     overflow <= 1'b0;
        else if (wr && full && !pop) overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)         snd_latch <= '0;
        else if (!empty) snd_latch <= head;
    end
`else
    localparam bit RESTART = 1'b1;

    assign more     = 1'b0;
    assign overflow = 1'b0;

    // Single latch: count is a 0/1 pending flag held for one edge, so the byte
    // reaches snd_latch and (re)starts the pulse on the edge after the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
        end else begin
            count <= wr ? CNT_W'(1) : '0;
            if (wr) head <= main_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          snd_latch <= '0;
        else if (has_cmd) snd_latch <= head;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
        end else if (RESTART && has_cmd) begin
            state     <= ST_PULSE;
            pulse_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (has_cmd) begin
                        state     <= ST_PULSE;
                        pulse_cnt <= '0;
                    end
                end
                ST_PULSE: begin
                    if (cen) begin
                        if (pulse_cnt == IRQ_LAST) begin
                            state  <= ST_WAIT;
                            to_cnt <= '0;
                        end else begin
                            pulse_cnt <= pulse_cnt + PULSE_TW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        state   <= more ? ST_GAP : ST_IDLE;
                        gap_cnt <= '0;
                    end else if (cen) begin
                        to_cnt <= to_cnt + TO_TW'(1);
                    end
                end
                ST_GAP: begin
                    if (cen) begin
                        if (gap_cnt == GAP_LAST) begin
                            state     <= ST_PULSE;
                            pulse_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_TW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Self-checking bench for jtcontra_snd_cmd: per-cycle vector table plus
// directed sequences for reset, pulse restart, FIFO pacing and overflow.
module tb_jtcontra_snd_cmd;

    localparam int IRQ_W_T   = 4;
    localparam int GAP_W_T   = 3;
    localparam int TIMEOUT_T = 16;
    localparam int DEPTH_T   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic       main_cs = 1'b0;
    logic       main_we = 1'b0;
    logic [7:0] main_din = 8'h00;
    logic       snd_ack = 1'b0;
    logic [7:0] snd_latch;
    logic       snd_irq;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    jtcontra_snd_cmd #(
        .IRQ_W   (IRQ_W_T),
        .GAP_W   (GAP_W_T),
        .TIMEOUT (TIMEOUT_T),
        .DEPTH   (DEPTH_T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .main_cs   (main_cs),
        .main_we   (main_we),
        .main_din  (main_din),
        .snd_ack   (snd_ack),
        .snd_latch (snd_latch),
        .snd_irq   (snd_irq),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, cen, cs, we, ack;
        logic [7:0] din;
        logic [7:0] e_latch;
        logic       e_irq, e_busy, e_ovf;
    } vec_t;

    vec_t vecs [48];
    int   nv = 0;

    task automatic add(input logic r, c, s, w, a, input logic [7:0] d,
                       input logic [7:0] el, input logic ei, eb);
        vecs[nv] = '{rst: r, cen: c, cs: s, we: w, ack: a, din: d,
                     e_latch: el, e_irq: ei, e_busy: eb, e_ovf: 1'b0};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, c, s, w, a, input logic [7:0] d);
        rst = r; cen = c; main_cs = s; main_we = w; snd_ack = a; main_din = d;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (snd_irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("irq_rise", {31'd0, snd_irq}, 32'd1);
    endtask

    task automatic measure_high(output int h);
        h = 0;
        while (snd_irq === 1'b1 && h < 100) begin
            h++;
            tick();
        end
    endtask

    int lows;
    int hi;
    int n;
    logic extra;
    logic [7:0] exp_seq [4];

    initial begin
        // Table: cycle-by-cycle vectors, identical in both latch and FIFO builds.
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 1, 1, 0, 8'h5A, 8'h00, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h5A, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h5A, 1, 1);
        add(0, 0, 0, 0, 0, 8'h00, 8'h5A, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h5A, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h5A, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h5A, 0, 1);
        add(0, 0, 1, 1, 0, 8'h77, 8'h5A, 0, 1);
        add(0, 0, 0, 0, 1, 8'h00, 8'h5A, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h5A, 0, 0);
        add(0, 1, 0, 0, 1, 8'h00, 8'h5A, 0, 0);
        add(0, 1, 1, 1, 0, 8'h3C, 8'h5A, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h3C, 1, 1);
        add(0, 1, 0, 0, 1, 8'h00, 8'h3C, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h3C, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h3C, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h3C, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 8'h3C, 0, 1);
        for (int i = 0; i < TIMEOUT_T - 1; i++)
            add(0, 1, 0, 0, 0, 8'h00, 8'h3C, 0, 1);
        add(0, 1, 0, 0, 0, 8'h00, 8'h3C, 0, 0);
        add(0, 1, 1, 0, 0, 8'hEE, 8'h3C, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h3C, 0, 0);
        add(0, 1, 0, 1, 0, 8'hEE, 8'h3C, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h3C, 0, 0);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].rst, vecs[i].cen, vecs[i].cs, vecs[i].we, vecs[i].ack, vecs[i].din);
            tick();
            chk($sformatf("vec%0d_latch", i), {24'd0, snd_latch}, {24'd0, vecs[i].e_latch});
            chk($sformatf("vec%0d_irq", i),   {31'd0, snd_irq},   {31'd0, vecs[i].e_irq});
            chk($sformatf("vec%0d_busy", i),  {31'd0, busy},      {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d_ovf", i),   {31'd0, overflow},  {31'd0, vecs[i].e_ovf});
        end

        // Reset with commands pending: everything cleared, nothing replays afterwards.
        drive(0, 1, 1, 1, 0, 8'h99); tick();
        drive(0, 1, 1, 1, 0, 8'h98); tick();
        idle_in(); tick();
        drive(1, 1, 1, 1, 0, 8'h97); tick();
        chk("rst_latch", {24'd0, snd_latch}, 32'h00);
        chk("rst_irq",   {31'd0, snd_irq},   32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_ovf",   {31'd0, overflow},  32'd0);
        idle_in();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst%0d_busy", i), {31'd0, busy}, 32'd0);
            chk($sformatf("post_rst%0d_latch", i), {24'd0, snd_latch}, 32'h00);
        end

`ifndef JTCONTRA_SNDCMD_FIFO_EN
        // Second write during PULSE overwrites the latch and restarts the pulse.
        drive(0, 1, 1, 1, 0, 8'h11); tick();
        chk("rs_w1_irq", {31'd0, snd_irq}, 32'd0);
        idle_in(); tick();
        chk("rs_p0_latch", {24'd0, snd_latch}, 32'h11);
        chk("rs_p0_irq", {31'd0, snd_irq}, 32'd1);
        tick();
        drive(0, 1, 1, 1, 0, 8'h22); tick();
        chk("rs_w2_irq", {31'd0, snd_irq}, 32'd1);
        chk("rs_w2_latch", {24'd0, snd_latch}, 32'h11);
        idle_in(); tick();
        chk("rs_restart_latch", {24'd0, snd_latch}, 32'h22);
        for (int i = 1; i < IRQ_W_T; i++) begin
            tick();
            chk($sformatf("rs_hold%0d_irq", i), {31'd0, snd_irq}, 32'd1);
        end
        tick();
        chk("rs_end_irq", {31'd0, snd_irq}, 32'd0);
        chk("rs_end_busy", {31'd0, busy}, 32'd1);
        chk("rs_ovf", {31'd0, overflow}, 32'd0);
        // A write while waiting for ack produces a fresh rising edge.
        drive(0, 1, 1, 1, 0, 8'h33); tick();
        chk("rs_w3_irq", {31'd0, snd_irq}, 32'd0);
        idle_in(); tick();
        chk("rs_w3_rise", {31'd0, snd_irq}, 32'd1);
        chk("rs_w3_latch", {24'd0, snd_latch}, 32'h33);
        for (int i = 0; i < IRQ_W_T; i++) tick();
        chk("rs_w3_fall", {31'd0, snd_irq}, 32'd0);
        drive(0, 1, 0, 0, 1, 8'h00); tick();
        idle_in();
        chk("rs_ack_busy", {31'd0, busy}, 32'd0);
        chk("rs_ack_latch", {24'd0, snd_latch}, 32'h33);
`else
        // Three back-to-back commands, each acknowledged in WAIT.
        drive(0, 1, 1, 1, 0, 8'h01); tick();
        drive(0, 1, 1, 1, 0, 8'h02); tick();
        drive(0, 1, 1, 1, 0, 8'h03); tick();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            wait_rise(lows);
            if (k > 0) chk($sformatf("seq%0d_gap", k), lows, GAP_W_T);
            chk($sformatf("seq%0d_latch", k), {24'd0, snd_latch}, k + 1);
            measure_high(hi);
            // The first pulse began one clock before measurement started.
            chk($sformatf("seq%0d_width", k), hi, (k == 0) ? IRQ_W_T - 1 : IRQ_W_T);
            tick();
            drive(0, 1, 0, 0, 1, 8'h00); tick();
            idle_in();
        end
        chk("seq_idle_busy", {31'd0, busy}, 32'd0);
        chk("seq_idle_latch", {24'd0, snd_latch}, 32'h03);

        // Fill to full, push+pop at full is accepted, then a plain push is dropped.
        for (int i = 0; i < DEPTH_T; i++) begin
            drive(0, 1, 1, 1, 0, 8'(8'hA0 + i)); tick();
        end
        idle_in();
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin tick(); n++; end
        chk("full_wait_irq", {31'd0, snd_irq}, 32'd0);
        chk("full_wait_busy", {31'd0, busy}, 32'd1);
        chk("full_ovf0", {31'd0, overflow}, 32'd0);
        drive(0, 1, 1, 1, 1, 8'hB5); tick();
        chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
        drive(0, 1, 1, 1, 0, 8'hC6); tick();
        idle_in();
        chk("full_drop_ovf", {31'd0, overflow}, 32'd1);
        exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3; exp_seq[3] = 8'hB5;
        for (int k = 0; k < 4; k++) begin
            wait_rise(lows);
            if (k > 0) chk($sformatf("to%0d_lowtime", k), lows, TIMEOUT_T + GAP_W_T);
            chk($sformatf("to%0d_latch", k), {24'd0, snd_latch}, {24'd0, exp_seq[k]});
            n = 0;
            while (snd_irq === 1'b1 && n < 20) begin tick(); n++; end
        end
        extra = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            if (snd_irq === 1'b1) extra = 1'b1;
            n++;
        end
        chk("to_idle_busy", {31'd0, busy}, 32'd0);
        chk("to_no_extra_irq", {31'd0, extra}, 32'd0);
        chk("to_final_latch", {24'd0, snd_latch}, 32'hB5);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        drive(1, 1, 0, 0, 0, 8'h00); tick();
        idle_in();
        chk("ovf_rst", {31'd0, overflow}, 32'd0);
        chk("ovf_rst_latch", {24'd0, snd_latch}, 32'h00);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
